// File: rtl/smr_pkg.sv
// Shared types for the special-modulus reducer: operating modes, FSM states
// and the accumulator sizing helper.
package smr_pkg;

   typedef enum logic [1:0] {
      MODE_MERSENNE,
      MODE_FERMAT,
      MODE_UNSUP
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      FOLD,
      CORRECT,
      DONE
   } state_e;

   // Headroom for up to maxChunks summed k-bit chunks plus a sign bit.
   function automatic int accWidth(input int w, input int maxChunks);
      return w + $clog2(maxChunks) + 2;
   endfunction

endpackage

// File: rtl/smr_mod_classify.sv
// Combinational modulus classifier: recognises 2^k-1 and 2^k+1 moduli from
// the modulus and its bit length, and checks the chunk count fits.
module smr_mod_classify
   import smr_pkg::*;
#(
   parameter  int W          = 64,
   parameter  int XW         = 128,
   parameter  int MAX_CHUNKS = 8,
   localparam int BLW        = $clog2(W + 1)
) (
   input  logic [W-1:0]   m_i,
   input  logic [BLW-1:0] m_bl_i,
   output mode_e          mode_o,
   output logic [BLW-1:0] k_o,
   output logic           chunks_ok_o
);

   logic [BLW-1:0] blMinus1;
   logic [W-1:0]   mersenneVal;
   logic [W-1:0]   fermatVal;

   always_comb begin
      blMinus1    = m_bl_i - BLW'(1);
      // A shift by exactly W wraps to zero, so bl==W still gives the all-ones pattern.
      mersenneVal = (W'(1) << m_bl_i) - W'(1);
      fermatVal   = (W'(1) << blMinus1) + W'(1);
      mode_o      = MODE_UNSUP;
      k_o         = '0;
      if (m_bl_i >= BLW'(2) && m_bl_i <= BLW'(W)) begin
         if (m_i == mersenneVal) begin
            mode_o = MODE_MERSENNE;
            k_o    = m_bl_i;
         end else if (m_i == fermatVal) begin
            mode_o = MODE_FERMAT;
            k_o    = blMinus1;
         end
      end
      chunks_ok_o = (k_o != '0) && ((32'(k_o) * 32'(MAX_CHUNKS)) >= 32'(XW));
   end

endmodule

// File: rtl/special_mod_reduce.sv
// Serial shift-add reducer computing x mod m for 2^k-1 / 2^k+1 moduli.
// Define SMR_CONST_TIME_EN for data-independent fold and correction timing.
module special_mod_reduce
   import smr_pkg::*;
#(
   parameter  int W          = 64,
   parameter  int XW         = 128,
   parameter  int MAX_CHUNKS = 8,
   localparam int BLW        = $clog2(W + 1)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [XW-1:0]  x_i,
   input  logic [W-1:0]   m_i,
   input  logic [BLW-1:0] m_bl_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [W-1:0]   result_o,
   output mode_e          mode_o,
   output logic           err_o
);

   localparam int AW   = accWidth(W, MAX_CHUNKS);
   localparam int IDXW = $clog2(MAX_CHUNKS) + 1;
   localparam int SHW  = $clog2(MAX_CHUNKS * W + 1);

   mode_e                clsMode;
   mode_e                inMode;
   logic [BLW-1:0]       clsK;
   logic                 clsChunksOk;
   logic [W-1:0]         inMask;

   state_e               stateQ;
   logic [XW-1:0]        xQ;
   logic [W-1:0]         mQ;
   logic [W-1:0]         kMaskQ;
   logic [BLW-1:0]       kQ;
   mode_e                modeQ;
   logic signed [AW-1:0] accQ;
   logic [IDXW-1:0]      idxQ;
   logic [W-1:0]         resultQ;
   logic                 outValidQ;
   logic                 inReadyQ;
   logic                 errQ;

   logic [SHW-1:0]       shiftAmt;
   logic [W-1:0]         chunk;
   logic signed [AW-1:0] chunkExt;
   logic signed [AW-1:0] mExt;
   logic signed [AW-1:0] foldAccD;
   logic signed [AW-1:0] corrAccD;
   logic                 foldLast;
   logic                 corrLast;
`ifndef SMR_CONST_TIME_EN
   logic [SHW-1:0]       nextShift;
`endif

   smr_mod_classify #(
      .W          (W),
      .XW         (XW),
      .MAX_CHUNKS (MAX_CHUNKS)
   ) uClassify (
      .m_i         (m_i),
      .m_bl_i      (m_bl_i),
      .mode_o      (clsMode),
      .k_o         (clsK),
      .chunks_ok_o (clsChunksOk)
   );

   // Chunk extraction and the fold/correct arithmetic for the current step.
   // Correction looks one step ahead so the final in-range value is registered
   // in the same cycle it appears, keeping the correction count within MAX_CHUNKS.
   always_comb begin
      inMode   = clsChunksOk ? clsMode : MODE_UNSUP;
      inMask   = (W'(1) << clsK) - W'(1);
      shiftAmt = SHW'(idxQ) * SHW'(kQ);
      chunk    = W'(xQ >> shiftAmt) & kMaskQ;
      chunkExt = $signed({{(AW - W){1'b0}}, chunk});
      mExt     = $signed({{(AW - W){1'b0}}, mQ});
      foldAccD = (modeQ == MODE_FERMAT && idxQ[0]) ? accQ - chunkExt : accQ + chunkExt;
      if (accQ[AW-1]) begin
         corrAccD = accQ + mExt;
      end else if (accQ >= mExt) begin
         corrAccD = accQ - mExt;
      end else begin
         corrAccD = accQ;
      end
`ifdef SMR_CONST_TIME_EN
      foldLast = (idxQ == IDXW'(MAX_CHUNKS - 1));
      corrLast = (idxQ == IDXW'(MAX_CHUNKS - 1));
`else
      nextShift = shiftAmt + SHW'(kQ);
      foldLast  = (nextShift >= SHW'(XW)) || ((xQ >> nextShift) == '0);
      corrLast  = !corrAccD[AW-1] && (corrAccD < mExt);
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stateQ    <= IDLE;
         xQ        <= '0;
         mQ        <= '0;
         kMaskQ    <= '0;
         kQ        <= '0;
         modeQ     <= MODE_UNSUP;
         accQ      <= '0;
         idxQ      <= '0;
         resultQ   <= '0;
         outValidQ <= 1'b0;
         inReadyQ  <= 1'b1;
         errQ      <= 1'b0;
      end else begin
         case (stateQ)
            IDLE: begin
               if (in_valid_i) begin
                  xQ       <= x_i;
                  mQ       <= m_i;
                  kQ       <= clsK;
                  kMaskQ   <= inMask;
                  modeQ    <= inMode;
                  accQ     <= $signed({{(AW - W){1'b0}}, x_i[W-1:0] & inMask});
                  idxQ     <= IDXW'(1);
                  inReadyQ <= 1'b0;
                  if (inMode == MODE_UNSUP) begin
                     errQ      <= 1'b1;
                     resultQ   <= '0;
                     outValidQ <= 1'b1;
                     stateQ    <= DONE;
                  end else begin
                     errQ   <= 1'b0;
                     stateQ <= FOLD;
                  end
               end
            end
            FOLD: begin
               accQ <= foldAccD;
               if (foldLast) begin
                  idxQ   <= '0;
                  stateQ <= CORRECT;
               end else begin
                  idxQ <= idxQ + IDXW'(1);
               end
            end
            CORRECT: begin
               accQ <= corrAccD;
               idxQ <= idxQ + IDXW'(1);
               if (corrLast) begin
                  resultQ   <= corrAccD[W-1:0];
                  outValidQ <= 1'b1;
                  stateQ    <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  outValidQ <= 1'b0;
                  inReadyQ  <= 1'b1;
                  stateQ    <= IDLE;
               end
            end
            default: begin
               stateQ <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = inReadyQ;
   assign out_valid_o = outValidQ;
   assign result_o    = resultQ;
   assign mode_o      = modeQ;
   assign err_o       = errQ;

endmodule

// File: tb/tb_special_mod_reduce.sv
// Self-checking bench for special_mod_reduce: directed corner cases plus
// randomized operands checked against an arithmetic reference model.
module tb_special_mod_reduce;
   import smr_pkg::*;

   localparam int W          = 64;
   localparam int XW         = 128;
   localparam int MAX_CHUNKS = 8;
   localparam int BLW        = $clog2(W + 1);
   localparam int MAX_LAT    = 2 * MAX_CHUNKS + 1;

   logic           clk_i       = 1'b0;
   logic           rst_ni      = 1'b0;
   logic           in_valid_i  = 1'b0;
   logic           out_ready_i = 1'b1;
   logic [XW-1:0]  x_i         = '0;
   logic [W-1:0]   m_i         = '0;
   logic [BLW-1:0] m_bl_i      = '0;
   logic           in_ready_o;
   logic           out_valid_o;
   logic [W-1:0]   result_o;
   mode_e          mode_o;
   logic           err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   special_mod_reduce #(
      .W          (W),
      .XW         (XW),
      .MAX_CHUNKS (MAX_CHUNKS)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .x_i         (x_i),
      .m_i         (m_i),
      .m_bl_i      (m_bl_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .mode_o      (mode_o),
      .err_o       (err_o)
   );

   // Reference classification straight from the modulus definitions.
   function automatic mode_e refMode(input logic [W-1:0] m, input int bl);
      logic [127:0] pow;
      mode_e        md;
      int           k;
      if (bl < 2 || bl > W) return MODE_UNSUP;
      pow = 128'(1) << bl;
      if (128'(m) == pow - 128'(1)) begin
         md = MODE_MERSENNE;
         k  = bl;
      end else if (128'(m) == (pow >> 1) + 128'(1)) begin
         md = MODE_FERMAT;
         k  = bl - 1;
      end else begin
         return MODE_UNSUP;
      end
      if ((XW + k - 1) / k > MAX_CHUNKS) return MODE_UNSUP;
      return md;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one operand, waits for acceptance and then for the result.
   // lat counts cycles from the accepting cycle (1) to the first out_valid cycle.
   task automatic applyStimulus(input logic [XW-1:0] x, input logic [W-1:0] m, input int bl,
                                output int lat);
      int waitCnt;
      @(negedge clk_i);
      x_i        = x;
      m_i        = m;
      m_bl_i     = BLW'(bl);
      in_valid_i = 1'b1;
      waitCnt    = 0;
      while (in_ready_o !== 1'b1 && waitCnt < 40) begin
         @(negedge clk_i);
         waitCnt++;
      end
      checkOutput("acceptTimeout", 128'(waitCnt < 40), 128'(1));
      @(negedge clk_i);
      in_valid_i = 1'b0;
      x_i        = {$urandom, $urandom, $urandom, $urandom};
      m_i        = {$urandom, $urandom};
      m_bl_i     = BLW'($urandom_range(0, W));
      lat        = 2;
      while (out_valid_o !== 1'b1 && lat < 60) begin
         @(negedge clk_i);
         lat++;
      end
      checkOutput("doneTimeout", 128'(lat < 60), 128'(1));
   endtask

   task automatic runOp(input string tag, input logic [XW-1:0] x, input logic [W-1:0] m, input int bl);
      int           lat;
      mode_e        expMode;
      logic [W-1:0] expRes;
      expMode = refMode(m, bl);
      expRes  = (expMode == MODE_UNSUP) ? '0 : W'(x % 128'(m));
      applyStimulus(x, m, bl, lat);
      checkOutput({tag, ".result"}, 128'(result_o), 128'(expRes));
      checkOutput({tag, ".mode"}, 128'(mode_o), 128'(expMode));
      checkOutput({tag, ".err"}, 128'(err_o), 128'(expMode == MODE_UNSUP));
      if (expMode == MODE_UNSUP) begin
         checkOutput({tag, ".latUnsup"}, 128'(lat), 128'(2));
      end else begin
`ifdef SMR_CONST_TIME_EN
         checkOutput({tag, ".latConst"}, 128'(lat), 128'(MAX_LAT));
`else
         checkOutput({tag, ".latBound"}, 128'(lat <= MAX_LAT), 128'(1));
`endif
      end
      @(negedge clk_i);
      checkOutput({tag, ".validDrop"}, 128'(out_valid_o), 128'(0));
   endtask

   initial begin
      logic [XW-1:0] ones;
      logic [XW-1:0] rx;
      logic [W-1:0]  rm;
      int            rbl;
      int            k;
      int            lat;

      ones = '1;
      $display("[TB] start");

      repeat (3) @(negedge clk_i);
      checkOutput("reset.inReady", 128'(in_ready_o), 128'(1));
      checkOutput("reset.outValid", 128'(out_valid_o), 128'(0));
      checkOutput("reset.result", 128'(result_o), 128'(0));
      checkOutput("reset.mode", 128'(mode_o), 128'(MODE_UNSUP));
      checkOutput("reset.err", 128'(err_o), 128'(0));
      rst_ni = 1'b1;

      runOp("mers61", 128'(1) << 122, W'((128'(1) << 61) - 1), 61);
      checkOutput("mers61.one", 128'(result_o), 128'(1));
      runOp("ferm2p16", 128'(1) << 16, 64'd65537, 17);
      checkOutput("ferm2p16.val", 128'(result_o), 128'(65536));
      runOp("ferm2p32", 128'(1) << 32, 64'd65537, 17);
      checkOutput("ferm2p32.one", 128'(result_o), 128'(1));
      runOp("fermOnes", ones, 64'd65537, 17);
      runOp("mers16Ones", ones, 64'd65535, 16);
      runOp("mers64", ones, '1, 64);
      runOp("ferm63", ones, W'((128'(1) << 63) + 1), 64);
      runOp("unsup12345", ones, 64'd12345, 14);
      checkOutput("unsup12345.errHi", 128'(err_o), 128'(1));
      runOp("mers7", ones, 64'd127, 7);
      checkOutput("mers7.errHi", 128'(err_o), 128'(1));
      runOp("tieM3", ones, 64'd3, 2);
      runOp("bl1", ones, 64'd1, 1);

`ifdef SMR_CONST_TIME_EN
      runOp("ctZero", '0, W'((128'(1) << 61) - 1), 61);
      runOp("ctOnes", ones, W'((128'(1) << 61) - 1), 61);
`endif

      // Hold the result under backpressure while a new operand is offered.
      out_ready_i = 1'b0;
      applyStimulus(128'(1) << 32, 64'd65537, 17, lat);
      for (int i = 0; i < 10; i++) begin
         in_valid_i = 1'b1;
         x_i        = {$urandom, $urandom, $urandom, $urandom};
         m_i        = 64'd65535;
         m_bl_i     = BLW'(16);
         checkOutput("bp.valid", 128'(out_valid_o), 128'(1));
         checkOutput("bp.inReady", 128'(in_ready_o), 128'(0));
         checkOutput("bp.result", 128'(result_o), 128'(1));
         checkOutput("bp.mode", 128'(mode_o), 128'(MODE_FERMAT));
         checkOutput("bp.err", 128'(err_o), 128'(0));
         @(negedge clk_i);
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      checkOutput("bp.validDrop", 128'(out_valid_o), 128'(0));
      checkOutput("bp.idleReady", 128'(in_ready_o), 128'(1));
      checkOutput("bp.noAccept", 128'(result_o), 128'(1));

      // Reset pulse while folding discards the operation immediately.
      x_i        = ones;
      m_i        = 64'd65537;
      m_bl_i     = BLW'(17);
      in_valid_i = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("rst.busy", 128'(in_ready_o), 128'(0));
      rst_ni = 1'b0;
      #1;
      checkOutput("rst.outValid", 128'(out_valid_o), 128'(0));
      checkOutput("rst.inReady", 128'(in_ready_o), 128'(1));
      checkOutput("rst.mode", 128'(mode_o), 128'(MODE_UNSUP));
      @(negedge clk_i);
      rst_ni = 1'b1;
      runOp("postRst", 128'(1) << 62, W'((128'(1) << 31) - 1), 31);
      checkOutput("postRst.one", 128'(result_o), 128'(1));

      for (int i = 0; i < 30; i++) begin
         rx = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
         case ($urandom_range(0, 3))
            0: begin
               k   = $urandom_range(16, 64);
               rm  = W'((128'(1) << k) - 1);
               rbl = k;
            end
            1: begin
               k   = $urandom_range(16, 63);
               rm  = W'((128'(1) << k) + 1);
               rbl = k + 1;
            end
            2: begin
               rm  = {$urandom, $urandom};
               rbl = $urandom_range(0, W);
            end
            default: begin
               k   = $urandom_range(2, 15);
               rm  = W'((128'(1) << k) - 1);
               rbl = k;
            end
         endcase
         runOp($sformatf("rand%0d", i), rx, rm, rbl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
